// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller: FSM states,
// special digit codes, anode patterns and the BCD conversion helper.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Digit codes beyond 0..9
  localparam logic [3:0] DASH  = 4'd10;
  localparam logic [3:0] BLANK = 4'd11;

  // Active-low anode enables, one per scan slot; slot 0 drives the leftmost digit
  localparam logic [3:0] ANODE_D3 = 4'b0111;
  localparam logic [3:0] ANODE_D2 = 4'b1011;
  localparam logic [3:0] ANODE_D1 = 4'b1101;
  localparam logic [3:0] ANODE_D0 = 4'b1110;

  // Width of the binary magnitude, which is also the number of double-dabble steps
  localparam int CONV_BITS  = 12;
  localparam int BCD_DIGITS = 4;

  // Largest magnitude a negative value can show with only three digits
  localparam logic [CONV_BITS-1:0] NEG_LIMIT = 12'd999;

  // Double-dabble correction: a digit of 5 or more would overflow when doubled
  function automatic logic [3:0] bcd_adjust(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Digit-code to active-low segment decoder, segment order {a,b,c,d,e,f,g}.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  // Pure lookup; DASH lights only segment g, everything else unknown is dark
  always_comb begin
    seg = 7'b1111111;
    case (code)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      DASH:    seg = 7'b1111110;
      BLANK:   seg = 7'b1111111;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Signed 12-bit value to 4-digit multiplexed seven-segment display.
// A value is accepted in IDLE, converted to BCD over 12 cycles, then
// committed to the display registers in a single COMMIT cycle. The
// refresh counter free-runs so the scan never stalls during conversion.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int REFRESH_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [11:0] in_mag,
  input  logic        blank_lz,
  output logic        busy,
  output logic        ovf,
  output logic [3:0]  Anode,
  output logic [6:0]  LED_out
);

  localparam logic [REFRESH_BITS-1:0] CNT_ONE   = REFRESH_BITS'(1);
  localparam logic [3:0]              STEP_LAST = 4'(CONV_BITS - 1);

  // Control and captured request
  state_t                 state_reg;
  logic                   ready_reg;
  logic                   busy_reg;
  logic                   ovf_reg;
  logic                   sign_reg;
  logic                   blank_reg;
  logic [CONV_BITS-1:0]   mag_reg;

  // Double-dabble working registers
  logic [CONV_BITS-1:0]   bin_reg;
  logic [4*BCD_DIGITS-1:0] bcd_reg;
  logic [3:0]             step_reg;
  logic [11:0]            bcd_adj;
  logic [4*BCD_DIGITS-1:0] bcd_next;

  // Display registers, index 3 is the leftmost digit
  logic [3:0][3:0]        disp_reg;
  logic [3:0][3:0]        disp_next;
  logic                   ovf_next;
  logic                   is_neg;
  logic                   leading;

  // Scan path
  logic [REFRESH_BITS-1:0] refresh_cnt_reg;
  logic [1:0]             scan_sel;
  logic [3:0]             scan_code;

  assign in_ready = ready_reg;
  assign busy     = busy_reg;
  assign ovf      = ovf_reg;

  // Add-3 correction for the lower three BCD digits. The thousands digit
  // never reaches 5 before the last shift (4095 tops out at 4), so it is
  // shifted without correction.
  for (genvar gi = 0; gi < BCD_DIGITS - 1; gi++) begin : g_adj
    assign bcd_adj[gi*4 +: 4] = bcd_adjust(bcd_reg[gi*4 +: 4]);
  end

  assign bcd_next = {bcd_reg[14:12], bcd_adj, bin_reg[CONV_BITS-1]};

  // Final digit codes and overflow flag derived from the finished conversion
  always_comb begin
    disp_next = bcd_reg;
    ovf_next  = 1'b0;
    leading   = 1'b1;
    // A signed zero is shown as a plain positive zero
    is_neg    = sign_reg && (mag_reg != '0);

    if (is_neg && (mag_reg > NEG_LIMIT)) begin
      ovf_next  = 1'b1;
      disp_next = {DASH, 4'd9, 4'd9, 4'd9};
    end else if (is_neg) begin
      disp_next = {DASH, bcd_reg[11:8], bcd_reg[7:4], bcd_reg[3:0]};
    end

    // Blank zeros to the left of the first significant digit; the dash is
    // skipped over and the ones digit is always shown
    if (blank_reg) begin
      for (int i = 3; i >= 1; i--) begin
        if (leading && (disp_next[i] != DASH)) begin
          if (disp_next[i] == 4'd0) begin
            disp_next[i] = BLANK;
          end else begin
            leading = 1'b0;
          end
        end
      end
    end
  end

  // Free-running refresh counter, wraps naturally from all-ones to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt_reg <= '0;
    end else begin
      refresh_cnt_reg <= refresh_cnt_reg + CNT_ONE;
    end
  end

  // Accept / convert / commit sequencer with registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      ready_reg <= 1'b1;
      busy_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      sign_reg  <= 1'b0;
      blank_reg <= 1'b0;
      mag_reg   <= '0;
      bin_reg   <= '0;
      bcd_reg   <= '0;
      step_reg  <= '0;
      disp_reg  <= {BLANK, BLANK, BLANK, 4'd0};
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            sign_reg  <= in_sign;
            mag_reg   <= in_mag;
            blank_reg <= blank_lz;
            bin_reg   <= in_mag;
            bcd_reg   <= '0;
            step_reg  <= '0;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b1;
            state_reg <= ST_CONV;
          end
        end
        ST_CONV: begin
          bin_reg  <= {bin_reg[CONV_BITS-2:0], 1'b0};
          bcd_reg  <= bcd_next;
          step_reg <= step_reg + 4'd1;
          if (step_reg == STEP_LAST) begin
            state_reg <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          disp_reg  <= disp_next;
          ovf_reg   <= ovf_next;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign scan_sel = refresh_cnt_reg[REFRESH_BITS-1 -: 2];

  // Pick the anode pattern and digit code for the current scan slot
  always_comb begin
    Anode     = ANODE_D3;
    scan_code = disp_reg[3];
    case (scan_sel)
      2'd0: begin Anode = ANODE_D3; scan_code = disp_reg[3]; end
      2'd1: begin Anode = ANODE_D2; scan_code = disp_reg[2]; end
      2'd2: begin Anode = ANODE_D1; scan_code = disp_reg[1]; end
      2'd3: begin Anode = ANODE_D0; scan_code = disp_reg[0]; end
      default: begin Anode = ANODE_D3; scan_code = disp_reg[3]; end
    endcase
  end

  seg7_decode u_decode (
    .code (scan_code),
    .seg  (LED_out)
  );

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed and randomized checks of seg_scan_ctrl against a value-level model.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [11:0] in_mag;
  logic        blank_lz;
  logic        busy;
  logic        ovf;
  logic [3:0]  Anode;
  logic [6:0]  LED_out;

  int checks   = 0;
  int failures = 0;

  // Model of what the display should currently show: codes per position 0..3
  int model_code [4];
  logic model_ovf;

  seg_scan_ctrl #(.REFRESH_BITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sign  (in_sign),
    .in_mag   (in_mag),
    .blank_lz (blank_lz),
    .busy     (busy),
    .ovf      (ovf),
    .Anode    (Anode),
    .LED_out  (LED_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int code);
    case (code)
      0: return 7'b0000001;  1: return 7'b1001111;
      2: return 7'b0010010;  3: return 7'b0000110;
      4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;
      8: return 7'b0000000;  9: return 7'b0000100;
      10: return 7'b1111110;
      default: return 7'b1111111;
    endcase
  endfunction

  // What the display should read for a committed value
  task automatic model_commit(input bit s, input int mag, input bit bl);
    int pow10 [4] = '{1, 10, 100, 1000};
    int v;
    bit neg;
    neg = s && (mag != 0);
    v = mag;
    model_ovf = 1'b0;
    if (neg && mag > 999) begin
      v = 999;
      model_ovf = 1'b1;
    end
    for (int p = 0; p < 4; p++) model_code[p] = (v / pow10[p]) % 10;
    if (neg) model_code[3] = 10;
    if (bl) begin
      for (int p = 3; p >= 1; p--) begin
        if (model_code[p] == 10) continue;
        if (model_code[p] != 0) break;
        model_code[p] = 11;
      end
    end
  endtask

  task automatic model_reset();
    model_code = '{0, 11, 11, 11};
    model_ovf  = 1'b0;
  endtask

  // Compare the currently scanned digit and ovf with the model
  task automatic check_now(input string tag);
    int pos;
    case (Anode)
      4'b0111: pos = 3;
      4'b1011: pos = 2;
      4'b1101: pos = 1;
      4'b1110: pos = 0;
      default: pos = -1;
    endcase
    if (pos < 0) check({tag, "_anode"}, 16'(Anode), 16'h000e);
    else check($sformatf("%s_d%0d", tag, pos), 16'(LED_out), 16'(seg_of(model_code[pos])));
    check({tag, "_ovf"}, 16'(ovf), 16'(model_ovf));
  endtask

  task automatic scan(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check_now(tag);
      tick();
    end
  endtask

  // Called just after the transfer edge T; follows the value through COMMIT
  task automatic run_conv(input string tag, input bit s, input int mag, input bit bl);
    for (int i = 0; i < 13; i++) begin
      check({tag, "_busy"}, 16'(busy), 16'h1);
      check_now({tag, "_old"});
      tick();
    end
    model_commit(s, mag, bl);
    check({tag, "_done_busy"}, 16'(busy), 16'h0);
    check({tag, "_done_ready"}, 16'(in_ready), 16'h1);
    scan({tag, "_new"}, 16);
    $display("txn %s sign=%0d mag=%0d blank=%0d -> codes %0d %0d %0d %0d ovf=%0d",
             tag, s, mag, bl, model_code[3], model_code[2], model_code[1], model_code[0], model_ovf);
  endtask

  task automatic do_transfer(input string tag, input bit s, input int mag, input bit bl);
    check({tag, "_ready"}, 16'(in_ready), 16'h1);
    in_valid = 1'b1;
    in_sign  = s;
    in_mag   = 12'(mag);
    blank_lz = bl;
    tick();
    in_valid = 1'b0;
    in_sign  = 1'b0;
    in_mag   = '0;
    blank_lz = 1'b0;
    run_conv(tag, s, mag, bl);
  endtask

  initial begin
    bit rs, rb;
    int rm;
    logic [3:0] pat [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_mag = '0; blank_lz = 1'b0;
    model_reset();
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    check("rst_ready", 16'(in_ready), 16'h1);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_anode", 16'(Anode), 16'h7);
    scan("rst", 16);
    $display("txn reset idle display checked");

    // Directed values
    do_transfer("p1234", 1'b0, 1234, 1'b0);
    do_transfer("n42_bl", 1'b1, 42, 1'b1);
    do_transfer("n2000", 1'b1, 2000, 1'b0);
    do_transfer("p4095", 1'b0, 4095, 1'b0);
    do_transfer("n2000b", 1'b1, 2000, 1'b1);
    do_transfer("neg0_bl", 1'b1, 0, 1'b1);
    do_transfer("p7_bl", 1'b0, 7, 1'b1);
    do_transfer("n5_bl", 1'b1, 5, 1'b1);
    do_transfer("p0", 1'b0, 0, 1'b0);

    // in_valid held through CONV with changing data
    in_valid = 1'b1; in_sign = 1'b0; in_mag = 12'd1357; blank_lz = 1'b0;
    tick();
    for (int i = 1; i <= 13; i++) begin
      in_sign  = 1'($urandom);
      in_mag   = 12'($urandom);
      blank_lz = 1'($urandom);
      if (i == 13) model_commit(1'b0, 1357, 1'b0);
      tick();
      if (i <= 12) begin
        check("hold_busy", 16'(busy), 16'h1);
      end else begin
        check("hold_ready", 16'(in_ready), 16'h1);
        check("hold_busy_low", 16'(busy), 16'h0);
      end
      check_now("hold_first");
    end
    in_sign = 1'b1; in_mag = 12'd305; blank_lz = 1'b1;
    tick();
    check("hold_second_busy", 16'(busy), 16'h1);
    check("hold_second_ready", 16'(in_ready), 16'h0);
    in_valid = 1'b0; in_sign = 1'b0; in_mag = '0; blank_lz = 1'b0;
    $display("txn hold first value 1357 shown, second transfer on first idle cycle");
    run_conv("hold_n305", 1'b1, 305, 1'b1);

    // Reset in the middle of converting +777; in_valid also high at the reset edge
    check("abort_ready", 16'(in_ready), 16'h1);
    in_valid = 1'b1; in_sign = 1'b0; in_mag = 12'd777; blank_lz = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("abort_busy_mid", 16'(busy), 16'h1);
    rst = 1'b1; in_valid = 1'b1; in_mag = 12'd888;
    tick();
    rst = 1'b0; in_valid = 1'b0; in_mag = '0;
    model_reset();
    check("abort_busy", 16'(busy), 16'h0);
    check("abort_ready2", 16'(in_ready), 16'h1);
    for (int k = 0; k < 32; k++) begin
      check($sformatf("wrap_anode_k%0d", k), 16'(Anode), 16'(pat[(k / 4) % 4]));
      check("abort_idle", 16'(busy), 16'h0);
      check_now("abort");
      tick();
    end
    $display("txn reset during conversion: display back to blank-blank-blank-0");

    // Randomized values
    for (int n = 0; n < 20; n++) begin
      rs = 1'($urandom);
      rb = 1'($urandom);
      case ($urandom % 4)
        0: rm = $urandom_range(0, 9);
        1: rm = $urandom_range(0, 99);
        2: rm = $urandom_range(0, 999);
        default: rm = $urandom_range(0, 4095);
      endcase
      do_transfer($sformatf("rnd%0d", n), rs, rm, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_BITS, default 20, meaning the refresh counter width; the digit select is counter[REFRESH_BITS-1:REFRESH_BITS-2].
REQ-002 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  new value offered.
REQ-005 in_ready  out  1  controller can accept a value.
REQ-006 in_sign  in  1  1 = negative.
REQ-007 in_mag  in  12  unsigned magnitude, 0..4095.
REQ-008 blank_lz  in  1  1 = suppress leading zeros; sampled with the value.
REQ-009 busy  out  1  conversion in progress.
REQ-010 ovf  out  1  last committed value was saturated.
REQ-011 Anode  out  4  active-low digit enables; bit 3 is the leftmost digit.
REQ-012 LED_out  out  7  active-low segments {a,b,c,d,e,f,g}; a is the MSB.

Function
REQ-013 SHALL transfer a value on a rising edge where in_valid and in_ready are both 1; in_sign, in_mag and blank_lz are captured then.
REQ-014 SHALL implement FSM IDLE -> CONV on transfer; CONV -> COMMIT after exactly 12 cycles; COMMIT -> IDLE after 1 cycle.
REQ-015 in_ready SHALL be 1 only in IDLE; busy SHALL be 1 in CONV and COMMIT; in_valid outside IDLE SHALL be ignored.
REQ-016 CONV SHALL perform a shift-add-3 (double-dabble) binary-to-BCD conversion, one bit per cycle, MSB first, producing 4 BCD digits (thousands..ones).
REQ-017 The display registers SHALL update on the COMMIT edge: transfer at edge T, new digits visible from edge T+13.
REQ-018 The display registers SHALL hold their value between commits; scanning SHALL never pause for conversion.
REQ-019 A negative value SHALL show '-' (code 10) in digit 3 and the hundreds/tens/ones in digits 2..0.
REQ-020 A negative value with magnitude > 999 SHALL display -999 and set ovf.
REQ-021 Positive values up to 4095 SHALL display exactly.
REQ-022 ovf SHALL be set or cleared at every COMMIT.
REQ-023 Sign with magnitude 0 SHALL display as positive 0 with ovf cleared.
REQ-024 If blank_lz=1, leading zero digits among positions 3..1 SHALL show blank (code 11); position 0 SHALL always show.
REQ-025 For a negative value with blank_lz=1, '-' SHALL remain in digit 3 and zeros in digits 2..1 that precede the first nonzero digit SHALL blank.
REQ-026 The refresh counter SHALL increment every cycle and wrap from all-ones to 0.
REQ-027 Select 00/01/10/11 SHALL drive Anode 0111/1011/1101/1110 with the digit 3/2/1/0 code respectively; Anode and LED_out are combinational from the counter and display registers.
REQ-028 Codes SHALL decode as: 0-9 to standard digits (0=0000001, 8=0000000), 10 to 1111110, 11 to 1111111; codes 12-15 SHALL map to 1111111.

Reset
REQ-029 rst SHALL force: FSM to IDLE, refresh counter to 0, display digits to {11,11,11,0} (shows "   0"), ovf 0, busy 0, and in_ready 1 in the following cycle.
REQ-030 rst asserted during CONV or COMMIT SHALL abort the conversion; the display SHALL NOT be updated with partial data.
REQ-031 A transfer SHALL NOT occur on an edge where rst=1.

Structure
REQ-032 Shared package seg_pkg SHALL hold: the FSM state enum, digit code constants (DASH=10, BLANK=11), the four Anode patterns, and the conversion bit count (12).
REQ-033 Code-to-segment decoding SHALL be a sub-module seg7_decode (4-bit code in, 7-bit segments out, combinational), instantiated once.

Verification (REFRESH_BITS=4 for simulation)
REQ-034 Reset, then no stimulus -> in_ready=1, ovf=0, digit 0 shows 0000001, digits 3..1 show 1111111.
REQ-035 Transfer +1234 with blank_lz=0 at edge T -> busy for 13 cycles, display is 1,2,3,4 from T+13, ovf=0.
REQ-036 Transfer -42 with blank_lz=1 -> digits show '-', blank, 4, 2 (1111110, 1111111, 1001100, 0010010).
REQ-037 Transfer -2000 -> display -999, ovf=1; then transfer +4095 -> display 4095, ovf=0.
REQ-038 in_valid held high through CONV with changing data -> only the first value is displayed, and a second transfer occurs on the first IDLE cycle.
REQ-039 rst pulsed at CONV cycle 6 of +777 -> display returns to "   0", no 777 ever appears; the counter wraps 15 -> 0 with the Anode sequence 0111, 1011, 1101, 1110 each held for 4 cycles.
